// File: rtl/edge_pattern_generator.sv
`default_nettype none
// ============================================================================
// Module      : edge_pattern_generator
// Description : Generates a train of num_pulses high pulses on pulse_out,
//               each high_len cycles wide and separated by low_len low
//               cycles. Edge strobes and a completion flag accompany the
//               waveform so it can drive edge-sensitive logic or be looped
//               back into an edge detector.
// Ports       : clk         - system clock, rising edge
//               reset       - synchronous reset, active-high
//               start       - begin a train (only when busy=0)
//               abort       - cancel a running train
//               high_len    - high phase length (0 treated as 1)
//               low_len     - low phase length (0 treated as 1)
//               num_pulses  - pulses per train (0 ignores start)
//               pulse_out   - generated waveform (registered)
//               rise_strobe - first cycle of each high phase
//               fall_strobe - first low cycle after a high phase
//               busy        - train in progress
//               done        - one-cycle flag on normal completion
// Revision    : 1.0 - initial release
// ============================================================================
module edge_pattern_generator #(
  parameter int CNT_W = 8,
  parameter int NUM_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  input  logic [NUM_W-1:0] num_pulses,
  output logic             pulse_out,
  output logic             rise_strobe,
  output logic             fall_strobe,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
  localparam logic [NUM_W-1:0] c_rem_one = NUM_W'(1);

  state_t           r_state,     w_state_nxt;
  logic [CNT_W-1:0] r_phase_cnt, w_phase_cnt_nxt;
  logic [CNT_W-1:0] r_high_len,  w_high_len_nxt;
  logic [CNT_W-1:0] r_low_len,   w_low_len_nxt;
  logic [NUM_W-1:0] r_remaining, w_remaining_nxt;
  logic             w_done_nxt;
  logic             w_pulse_nxt;
  logic [CNT_W-1:0] w_high_clamp;
  logic [CNT_W-1:0] w_low_clamp;

  // A zero length would otherwise underflow the phase counter on load.
  assign w_high_clamp = (high_len == '0) ? c_cnt_one : high_len;
  assign w_low_clamp  = (low_len  == '0) ? c_cnt_one : low_len;

  always_comb begin
    w_state_nxt     = r_state;
    w_phase_cnt_nxt = r_phase_cnt;
    w_high_len_nxt  = r_high_len;
    w_low_len_nxt   = r_low_len;
    w_remaining_nxt = r_remaining;
    w_done_nxt      = 1'b0;

    case (r_state)
      S_IDLE: begin
        // abort is deliberately not examined here: start wins in IDLE.
        if (start && (num_pulses != '0)) begin
          w_state_nxt     = S_HIGH;
          w_high_len_nxt  = w_high_clamp;
          w_low_len_nxt   = w_low_clamp;
          w_phase_cnt_nxt = w_high_clamp - c_cnt_one;
          w_remaining_nxt = num_pulses;
        end
      end

      S_HIGH: begin
        if (abort) begin
          w_state_nxt     = S_IDLE;
          w_remaining_nxt = '0;
        end else if (r_phase_cnt == '0) begin
          if (r_remaining == c_rem_one) begin
            // Last pulse: no trailing low phase is generated.
            w_state_nxt     = S_IDLE;
            w_remaining_nxt = '0;
            w_done_nxt      = 1'b1;
          end else begin
            w_state_nxt     = S_LOW;
            w_phase_cnt_nxt = r_low_len - c_cnt_one;
            w_remaining_nxt = r_remaining - c_rem_one;
          end
        end else begin
          w_phase_cnt_nxt = r_phase_cnt - c_cnt_one;
        end
      end

      S_LOW: begin
        if (abort) begin
          w_state_nxt     = S_IDLE;
          w_remaining_nxt = '0;
        end else if (r_phase_cnt == '0) begin
          w_state_nxt     = S_HIGH;
          w_phase_cnt_nxt = r_high_len - c_cnt_one;
        end else begin
          w_phase_cnt_nxt = r_phase_cnt - c_cnt_one;
        end
      end

      default: begin
        w_state_nxt     = S_IDLE;
        w_remaining_nxt = '0;
      end
    endcase
  end

  // The waveform is high exactly while the next state is HIGH; strobes are
  // derived from the change against the current registered waveform, which
  // also covers the abort case (fall only if the output was high).
  assign w_pulse_nxt = (w_state_nxt == S_HIGH);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_phase_cnt <= '0;
      r_high_len  <= '0;
      r_low_len   <= '0;
      r_remaining <= '0;
      pulse_out   <= 1'b0;
      rise_strobe <= 1'b0;
      fall_strobe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase_cnt <= w_phase_cnt_nxt;
      r_high_len  <= w_high_len_nxt;
      r_low_len   <= w_low_len_nxt;
      r_remaining <= w_remaining_nxt;
      pulse_out   <= w_pulse_nxt;
      rise_strobe <= w_pulse_nxt & ~pulse_out;
      fall_strobe <= ~w_pulse_nxt & pulse_out;
      busy        <= (w_state_nxt != S_IDLE);
      done        <= w_done_nxt;
    end
  end

endmodule
`default_nettype wire
